// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data RAM arbiter.
// Latency: n/a (declarations only). Backpressure: n/a.
// ARB_LOCK exists only when RAM_ARB_BURST_EN is defined.
package ram_arb_pkg;

    localparam int REG_BUS         = 32;
    localparam int REG_SEL         = 4;
    localparam int BURST_CNT_MAX_W = 8;

    // Records which master owned the RAM in the previous cycle.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_G0   = 2'd1,
        ARB_G1   = 2'd2
`ifdef RAM_ARB_BURST_EN
        ,
        ARB_LOCK = 2'd3
`endif
    } arb_state_t;

    // One master's RAM command, muxed as a unit onto the RAM port.
    typedef struct packed {
        logic                 we;
        logic [REG_BUS-1:0]   addr;
        logic [REG_SEL-1:0]   sel;
        logic [REG_BUS-1:0]   wdata;
    } ram_req_t;

    // Width that holds 0..max_burst, never wider than 8 bits.
    function automatic int burst_cnt_width(input int max_burst);
        int w;
        w = $clog2(max_burst + 1);
        return (w > BURST_CNT_MAX_W) ? BURST_CNT_MAX_W : w;
    endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Bundle of both master ports and the data_ram port of the arbiter.
// Latency: n/a (wires only). Backpressure: gnt/stall are driven by the arbiter.
// slave = arbiter view, master = masters-plus-RAM environment view.
interface data_ram_arbiter_if;
    import ram_arb_pkg::*;

    logic               m0_req;
    logic               m0_we;
    logic [REG_BUS-1:0] m0_addr;
    logic [REG_SEL-1:0] m0_sel;
    logic [REG_BUS-1:0] m0_wdata;
    logic               m0_gnt;
    logic               m0_stall;
    logic [REG_BUS-1:0] m0_rdata;

    logic               m1_req;
    logic               m1_we;
    logic [REG_BUS-1:0] m1_addr;
    logic [REG_SEL-1:0] m1_sel;
    logic [REG_BUS-1:0] m1_wdata;
    logic               m1_lock;
    logic               m1_gnt;
    logic [REG_BUS-1:0] m1_rdata;

    logic               ram_ce;
    logic               ram_we;
    logic [REG_BUS-1:0] ram_addr;
    logic [REG_SEL-1:0] ram_sel;
    logic [REG_BUS-1:0] ram_data_o;
    logic [REG_BUS-1:0] ram_data_i;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_lock,
        input  ram_data_i,
        output m0_gnt, m0_stall, m0_rdata,
        output m1_gnt, m1_rdata,
        output ram_ce, ram_we, ram_addr, ram_sel, ram_data_o
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_lock,
        output ram_data_i,
        input  m0_gnt, m0_stall, m0_rdata,
        input  m1_gnt, m1_rdata,
        input  ram_ce, ram_we, ram_addr, ram_sel, ram_data_o
    );

endinterface

// File: rtl/ram_arb_core.sv
// Round-robin grant FSM for two masters, optional locked master-1 burst (RAM_ARB_BURST_EN).
// Latency: grant is combinational from state and requests (zero-cycle).
// Backpressure: loser is simply not granted; rst forces both grants low.
import ram_arb_pkg::*;

module ram_arb_core #(
    parameter int MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       m1_lock,
    output logic [1:0] gnt
);

    arb_state_t state;
    arb_state_t state_nxt;

`ifdef RAM_ARB_BURST_EN
    localparam int            CW      = burst_cnt_width(MAX_BURST);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_cnt_nxt;
`else
    // Lock request and burst length have no meaning without the burst feature.
    localparam int unused_max_burst = MAX_BURST;
    logic unused_lock;
    assign unused_lock = m1_lock;
`endif

    // State register: remembers last owner (and burst length when enabled).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
`ifdef RAM_ARB_BURST_EN
            burst_cnt <= '0;
`endif
        end else begin
            state     <= state_nxt;
`ifdef RAM_ARB_BURST_EN
            burst_cnt <= burst_cnt_nxt;
`endif
        end
    end

    // Grant: lone requester wins; on contention the previous owner yields.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    case (state)
                        ARB_G0:   gnt = 2'b10;
`ifdef RAM_ARB_BURST_EN
                        // Dropping the lock mid-burst falls back to round-robin.
                        ARB_LOCK: gnt = (m1_lock && (burst_cnt < MAX_CNT)) ? 2'b10 : 2'b01;
`endif
                        default:  gnt = 2'b01;
                    endcase
                end
                default: gnt = 2'b00;
            endcase
        end
    end

    // Next state follows the grant; burst length counts locked master-1 grants.
    always_comb begin
        state_nxt = ARB_IDLE;
`ifdef RAM_ARB_BURST_EN
        burst_cnt_nxt = '0;
`endif
        if (gnt[0]) begin
            state_nxt = ARB_G0;
        end else if (gnt[1]) begin
`ifdef RAM_ARB_BURST_EN
            if (m1_lock) begin
                state_nxt = ARB_LOCK;
                if (state != ARB_LOCK) begin
                    burst_cnt_nxt = CW'(1);
                end else if (burst_cnt < MAX_CNT) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end else begin
                    burst_cnt_nxt = burst_cnt;
                end
            end else begin
                state_nxt = ARB_G1;
            end
`else
            state_nxt = ARB_G1;
`endif
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-port data RAM between the CPU data port (m0) and a loader/debug master (m1).
// Latency: zero-cycle grant; RAM drive and rdata valid in the request cycle, writes commit next edge.
// Backpressure: non-granted master is held off (m0 via m0_stall); nothing is driven during rst.
import ram_arb_pkg::*;

module data_ram_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               rst,
    data_ram_arbiter_if.slave  bus
);

    logic [1:0] gnt;
    ram_req_t   m0_cmd;
    ram_req_t   m1_cmd;
    ram_req_t   ram_cmd;

    ram_arb_core #(
        .MAX_BURST (MAX_BURST)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .req     ({bus.m1_req, bus.m0_req}),
        .m1_lock (bus.m1_lock),
        .gnt     (gnt)
    );

    assign m0_cmd = '{we: bus.m0_we, addr: bus.m0_addr, sel: bus.m0_sel, wdata: bus.m0_wdata};
    assign m1_cmd = '{we: bus.m1_we, addr: bus.m1_addr, sel: bus.m1_sel, wdata: bus.m1_wdata};

    // Request mux: the granted master's command, all-zero when idle.
    always_comb begin
        ram_cmd = '0;
        if (gnt[0]) begin
            ram_cmd = m0_cmd;
        end else if (gnt[1]) begin
            ram_cmd = m1_cmd;
        end
    end

    assign bus.ram_ce     = gnt[0] | gnt[1];
    assign bus.ram_we     = ram_cmd.we;
    assign bus.ram_addr   = ram_cmd.addr;
    assign bus.ram_sel    = ram_cmd.sel;
    assign bus.ram_data_o = ram_cmd.wdata;

    // Response mux: read data only reaches the master that owns the port.
    assign bus.m0_gnt   = gnt[0];
    assign bus.m1_gnt   = gnt[1];
    assign bus.m0_rdata = gnt[0] ? bus.ram_data_i : '0;
    assign bus.m1_rdata = gnt[1] ? bus.ram_data_i : '0;
    assign bus.m0_stall = bus.m0_req & ~gnt[0] & ~rst;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed stimulus with a scoreboard queue for the two-master data RAM arbiter.
// Stimulus drives one cycle at posedge+1 and queues the expected response;
// a negedge monitor pops and compares every DUT output of that cycle.
module tb_data_ram_arbiter;
    import ram_arb_pkg::*;

`ifdef RAM_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic        stall;
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    logic [31:0] mem [0:63];
    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   passed = 0;
    logic [0:7] burst_pat = 8'b0111_1010;
    logic [0:7] alt_pat   = 8'b0101_0101;
    logic       pat_g1;

    always #5 clk = ~clk;

    data_ram_arbiter_if bif ();

    data_ram_arbiter #(
        .MAX_BURST (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // data_ram model: combinational read, byte-lane write at the rising edge.
    assign bif.ram_data_i = mem[bif.ram_addr[7:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (bif.ram_ce && bif.ram_we) begin
            for (int b = 0; b < 4; b++)
                if (bif.ram_sel[b]) mem[bif.ram_addr[7:2]][8*b +: 8] <= bif.ram_data_o[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    endtask

    // One bus cycle: drive both masters, queue the hand-computed response.
    task automatic cyc(input logic r,
                       input logic q0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic q1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic lk, input logic eg0, input logic eg1,
                       input logic [31:0] ed0, input logic [31:0] ed1);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        bif.m0_req   = q0;
        bif.m0_we    = we0;
        bif.m0_addr  = a0;
        bif.m0_wdata = d0;
        bif.m1_req   = q1;
        bif.m1_we    = we1;
        bif.m1_addr  = a1;
        bif.m1_wdata = d1;
        bif.m1_lock  = lk;
        e.g0    = eg0;
        e.g1    = eg1;
        e.stall = q0 & ~eg0 & ~r;
        e.ce    = eg0 | eg1;
        e.we    = eg0 ? we0 : (eg1 ? we1 : 1'b0);
        e.addr  = eg0 ? a0  : (eg1 ? a1  : 32'h0);
        e.wdata = eg0 ? d0  : (eg1 ? d1  : 32'h0);
        e.sel   = (eg0 | eg1) ? 4'hF : 4'h0;
        e.rd0   = eg0 ? ed0 : 32'h0;
        e.rd1   = eg1 ? ed1 : 32'h0;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every output of the cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("m0_gnt",     32'(bif.m0_gnt),   32'(mon_e.g0));
            chk("m1_gnt",     32'(bif.m1_gnt),   32'(mon_e.g1));
            chk("m0_stall",   32'(bif.m0_stall), 32'(mon_e.stall));
            chk("ram_ce",     32'(bif.ram_ce),   32'(mon_e.ce));
            chk("ram_we",     32'(bif.ram_we),   32'(mon_e.we));
            chk("ram_addr",   bif.ram_addr,      mon_e.addr);
            chk("ram_data_o", bif.ram_data_o,    mon_e.wdata);
            chk("ram_sel",    32'(bif.ram_sel),  32'(mon_e.sel));
            chk("m0_rdata",   bif.m0_rdata,      mon_e.rd0);
            chk("m1_rdata",   bif.m1_rdata,      mon_e.rd1);
        end
    end

    initial begin
        bif.m0_req = 0; bif.m0_we = 0; bif.m0_addr = 0; bif.m0_sel = 4'hF; bif.m0_wdata = 0;
        bif.m1_req = 0; bif.m1_we = 0; bif.m1_addr = 0; bif.m1_sel = 4'hF; bif.m1_wdata = 0;
        bif.m1_lock = 0;
        @(posedge clk);
        #1 mem_clr = 1'b0;

        // Reset held with both requesting: nothing granted, no stall.
        cyc(1, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 32'h0, 32'h5, 1, 1, 32'h4, 32'h6, 0, 0, 0, 0, 0);

        // Both requesting from reset, no lock: 0,1,0,1.
        cyc(0, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0, 0, 0, 1, 0, 0);
        idle();

        // Master 0 alone: write then read back.
        cyc(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0);
        cyc(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0);
        idle();

        // Contention with m1 locked for 7 cycles, then lock dropped.
        for (int i = 0; i < 8; i++) begin
            pat_g1 = BURST ? burst_pat[i] : alt_pat[i];
            cyc(0, 1, 0, 32'h10, 0, 1, 0, 32'h14, 0, (i < 7), ~pat_g1, pat_g1, 32'hDEADBEEF, 32'h0);
        end
        idle();

        // Reset in the second cycle of an m1 write burst.
        cyc(0, 1, 1, 32'h24, 32'h11111111, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0);
        idle();
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'hAAAA5555, 1, 0, 1, 0, 32'h0);
        cyc(1, 1, 0, 32'h24, 0, 1, 1, 32'h24, 32'hBBBB0000, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 32'h24, 0, 1, 1, 32'h24, 32'hBBBB0000, 1, 1, 0, 32'h11111111, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h24, 32'hBBBB0000, 1, 0, 1, 0, 32'h11111111);
        cyc(0, 1, 0, 32'h24, 0, 0, 0, 0, 0, 1, 1, 0, 32'hBBBB0000, 0);
        cyc(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0, 32'hAAAA5555, 0);
        idle();
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
